// File: rtl/frame_packer.sv
// Frame aligner and MSB-first word packer between the pixel deserialiser and the readout FIFO.
// Optional FRAME_TRAILER_EN appends a {8'hE0, 0, frame_count} word after each completed frame.
module frame_packer #(
    parameter int unsigned              DATA_WIDTH   = 8,
    parameter int unsigned              FIFO_WIDTH   = 32,
    parameter int unsigned              FRAME_WIDTH  = 48,
    parameter logic [DATA_WIDTH-1:0]    FRAME_HEADER = 8'hBC,
    parameter int unsigned              LOCK_COUNT   = 2,
    parameter int unsigned              NFRAME_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    trigger,
    input  logic [NFRAME_WIDTH-1:0] nframes,
    input  logic [DATA_WIDTH-1:0]   fd_in,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]   data_out,
    output logic                    locked,
    output logic                    busy,
    output logic [15:0]             frame_count,
    output logic                    overflow,
    output logic                    lock_err
);

    localparam int unsigned BPW = FIFO_WIDTH / DATA_WIDTH;
    localparam int unsigned PW  = $clog2(FRAME_WIDTH);
    localparam int unsigned HW  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WW  = $clog2(BPW);

    localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_WIDTH - 1);
    localparam logic [HW-1:0] LOCK_MAX  = HW'(LOCK_COUNT);
    localparam logic [WW-1:0] WCNT_LAST = WW'(BPW - 1);

    typedef enum logic [1:0] {StIdle, StWaitHdr, StCapture} state_e;

    state_e                  state;
    logic [PW-1:0]           pos_q, pos_d;
    logic [HW-1:0]           hits_q, hits_d;
    logic                    locked_d;
    logic                    hdr_match, hdr_slot, hdr_bad, hdr_ok;
    logic [WW-1:0]           wcnt;
    logic [FIFO_WIDTH-1:0]   shreg;
    logic [FIFO_WIDTH-1:0]   word_d;
    logic [NFRAME_WIDTH-1:0] frames_left;
`ifdef FRAME_TRAILER_EN
    logic                    trl_pend;
`endif

    // pos_q is the frame position of the unit currently on fd_in.
    always_comb begin
        hdr_match = (fd_in == FRAME_HEADER);
        hdr_slot  = 1'b0;
        hdr_bad   = 1'b0;
        hits_d    = hits_q;
        pos_d     = pos_q;
        if (hits_q == '0) begin
            if (hdr_match) begin
                hdr_slot = 1'b1;
                hits_d   = HW'(1);
                pos_d    = PW'(1);
            end
        end else begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
            if (pos_q == '0) begin
                hdr_slot = 1'b1;
                if (hdr_match) begin
                    hits_d = (hits_q == LOCK_MAX) ? hits_q : hits_q + HW'(1);
                end else begin
                    hdr_bad = 1'b1;
                    hits_d  = '0;
                    pos_d   = '0;
                end
            end
        end
        locked_d = (hits_d == LOCK_MAX);
        hdr_ok   = hdr_slot && hdr_match && locked_d;
    end

    assign word_d = {shreg[FIFO_WIDTH-DATA_WIDTH-1:0], fd_in};
    assign busy   = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            pos_q       <= '0;
            hits_q      <= '0;
            locked      <= 1'b0;
            wcnt        <= '0;
            shreg       <= '0;
            frames_left <= '0;
            fifo_wr_en  <= 1'b0;
            data_out    <= '0;
            frame_count <= '0;
            overflow    <= 1'b0;
            lock_err    <= 1'b0;
`ifdef FRAME_TRAILER_EN
            trl_pend    <= 1'b0;
`endif
        end else begin
            pos_q      <= pos_d;
            hits_q     <= hits_d;
            locked     <= locked_d;
            fifo_wr_en <= 1'b0;
`ifdef FRAME_TRAILER_EN
            // BPW >= 4 guarantees no data word completes on the trailer cycle.
            trl_pend <= 1'b0;
            if (trl_pend) begin
                if (fifo_full) begin
                    overflow <= 1'b1;
                end else begin
                    fifo_wr_en <= 1'b1;
                    data_out   <= {8'hE0, {(FIFO_WIDTH-24){1'b0}}, frame_count};
                end
            end
`endif
            if (start || trigger) begin
                frames_left <= start ? nframes : NFRAME_WIDTH'(1);
                frame_count <= '0;
                overflow    <= 1'b0;
                lock_err    <= 1'b0;
                wcnt        <= '0;
                state       <= (start && nframes == '0) ? StIdle : StWaitHdr;
`ifdef FRAME_TRAILER_EN
                trl_pend    <= 1'b0;
`endif
            end else begin
                unique case (state)
                    StIdle: ;
                    StWaitHdr: begin
                        if (hdr_ok) begin
                            shreg <= word_d;
                            wcnt  <= WW'(1);
                            state <= StCapture;
                        end
                    end
                    StCapture: begin
                        if (hdr_bad) begin
                            lock_err <= 1'b1;
                            wcnt     <= '0;
                            state    <= StWaitHdr;
                        end else begin
                            shreg <= word_d;
                            wcnt  <= wcnt + WW'(1);
                            if (wcnt == WCNT_LAST) begin
                                wcnt <= '0;
                                if (fifo_full) begin
                                    // Rest of the frame is dropped; re-arm on the next header.
                                    overflow <= 1'b1;
                                    state    <= StWaitHdr;
                                end else begin
                                    fifo_wr_en <= 1'b1;
                                    data_out   <= word_d;
                                    if (pos_q == POS_LAST) begin
                                        frame_count <= frame_count + 16'd1;
                                        frames_left <= frames_left - NFRAME_WIDTH'(1);
`ifdef FRAME_TRAILER_EN
                                        trl_pend    <= 1'b1;
`endif
                                        if (frames_left == NFRAME_WIDTH'(1)) state <= StIdle;
                                    end
                                end
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: 48-unit frames of 0xBC followed by 0x01..0x2F.
module tb_frame_packer;

    localparam int FRW = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        trigger = 1'b0;
    logic [9:0]  nframes = '0;
    logic [7:0]  fd_in = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [31:0] data_out;
    logic        locked;
    logic        busy;
    logic [15:0] frame_count;
    logic        overflow;
    logic        lock_err;

    int total = 0;
    int bad = 0;
    int unit = 0;
    int hdr_cnt = 0;
    bit corrupt_next = 1'b0;
    longint cyc = 0;
    logic [31:0] wq[$];
    longint      wt[$];
    logic [31:0] tq[$];
    longint      tt[$];

    frame_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .trigger     (trigger),
        .nframes     (nframes),
        .fd_in       (fd_in),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .data_out    (data_out),
        .locked      (locked),
        .busy        (busy),
        .frame_count (frame_count),
        .overflow    (overflow),
        .lock_err    (lock_err)
    );

    always #5 clk = ~clk;

    // Pixel stream source; corrupt_next replaces the next header with 0x00.
    initial begin
        forever begin
            @(negedge clk);
            if (unit == 0) begin
                if (corrupt_next) begin
                    fd_in = 8'h00;
                    corrupt_next = 1'b0;
                end else begin
                    fd_in = 8'hBC;
                end
                hdr_cnt++;
            end else begin
                fd_in = 8'(unit);
            end
            unit = (unit == FRW - 1) ? 0 : unit + 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (fifo_wr_en === 1'b1) begin
                if (data_out[31:24] == 8'hE0) begin
                    tq.push_back(data_out);
                    tt.push_back(cyc);
                end else begin
                    wq.push_back(data_out);
                    wt.push_back(cyc);
                end
            end
        end
    end

    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++) begin
            int u = 4 * k + j;
            w = {w[23:0], (u == 0) ? 8'hBC : 8'(u)};
        end
        return w;
    endfunction

    task automatic clear_q();
        wq.delete();
        wt.delete();
        tq.delete();
        tt.delete();
    endtask

    task automatic pulse_trigger();
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic pulse_start(input logic [9:0] n);
        @(negedge clk);
        start = 1'b1;
        nframes = n;
        @(negedge clk);
        start = 1'b0;
        nframes = '0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        hdr_cnt = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", fifo_wr_en); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", data_out); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (frame_count !== 16'h0) begin bad++; $display("FAIL rst_count: got %0d want 0", frame_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        total++; if (lock_err !== 1'b0) begin bad++; $display("FAIL rst_lock_err: got %b want 0", lock_err); end
    endtask

    task automatic test_lock();
        int n = 0;
        int errs = 0;
        release_reset();
        while (locked !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        total++; if (n >= 200) begin bad++; $display("FAIL lock_timeout: locked=%b want 1", locked); end
        total++; if (hdr_cnt != 2) begin bad++; $display("FAIL lock_hdr: lock at header %0d want 2", hdr_cnt); end
        clear_q();
        pulse_trigger();
        n = 0;
        while (busy !== 1'b0 && n < 300) begin @(posedge clk); #1; n++; end
        total++; if (n >= 300) begin bad++; $display("FAIL trig_timeout: busy=%b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (wq.size() != 12) begin bad++; $display("FAIL trig_nwords: got %0d want 12", wq.size()); end
        if (wq.size() == 12) begin
            total++; if (wq[0] !== 32'hBC010203) begin bad++; $display("FAIL trig_first: got %h want bc010203", wq[0]); end
            total++; if (wq[11] !== 32'h2C2D2E2F) begin bad++; $display("FAIL trig_last: got %h want 2c2d2e2f", wq[11]); end
        end
        for (int i = 0; i < wq.size(); i++) if (wq[i] !== exp_word(i % 12)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL trig_words: wrong=%0d want 0", errs); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL trig_count: got %0d want 1", frame_count); end
`ifdef FRAME_TRAILER_EN
        total++; if (tq.size() != 1) begin bad++; $display("FAIL trig_trailers: got %0d want 1", tq.size()); end
`else
        total++; if (tq.size() != 0) begin bad++; $display("FAIL trig_trailers: got %0d want 0", tq.size()); end
`endif
    endtask

    task automatic test_auto();
        int n = 0;
        int errs = 0;
        int gaps = 0;
        clear_q();
        pulse_start(10'd3);
        while (busy !== 1'b0 && n < 600) begin @(posedge clk); #1; n++; end
        total++; if (n >= 600) begin bad++; $display("FAIL auto_timeout: busy=%b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (wq.size() != 36) begin bad++; $display("FAIL auto_nwords: got %0d want 36", wq.size()); end
        for (int i = 1; i < wt.size(); i++) if (wt[i] - wt[i-1] != 4) gaps++;
        total++; if (gaps != 0) begin bad++; $display("FAIL auto_spacing: bad_gaps=%0d want 0", gaps); end
        for (int i = 0; i < wq.size(); i++) if (wq[i] !== exp_word(i % 12)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL auto_words: wrong=%0d want 0", errs); end
        total++; if (frame_count !== 16'd3) begin bad++; $display("FAIL auto_count: got %0d want 3", frame_count); end
`ifdef FRAME_TRAILER_EN
        total++; if (tq.size() != 3) begin bad++; $display("FAIL auto_trailers: got %0d want 3", tq.size()); end
        if (tq.size() == 3 && wq.size() == 36) begin
            for (int i = 0; i < 3; i++) begin
                logic [31:0] et = 32'hE0000000 | 32'(i + 1);
                total++; if (tq[i] !== et) begin bad++; $display("FAIL auto_trl_val: got %h want %h", tq[i], et); end
                total++; if (tt[i] != wt[12*i+11] + 1) begin bad++; $display("FAIL auto_trl_time: got %0d want %0d", tt[i], wt[12*i+11] + 1); end
            end
        end
`else
        total++; if (tq.size() != 0) begin bad++; $display("FAIL auto_trailers: got %0d want 0", tq.size()); end
`endif
    endtask

    task automatic test_lock_loss();
        int n = 0;
        int errs = 0;
        clear_q();
        pulse_start(10'd3);
        while (frame_count !== 16'd2 && n < 400) begin @(posedge clk); #1; n++; end
        total++; if (n >= 400) begin bad++; $display("FAIL loss_wait2: count=%0d want 2", frame_count); end
        corrupt_next = 1'b1;
        n = 0;
        while (lock_err !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        total++; if (n >= 100) begin bad++; $display("FAIL loss_err: lock_err=%b want 1", lock_err); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_locked: got %b want 0", locked); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL loss_busy: got %b want 1", busy); end
        total++; if (wq.size() != 24) begin bad++; $display("FAIL loss_partial: got %0d words want 24", wq.size()); end
        n = 0;
        while (busy !== 1'b0 && n < 400) begin @(posedge clk); #1; n++; end
        total++; if (n >= 400) begin bad++; $display("FAIL loss_timeout: busy=%b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (wq.size() != 36) begin bad++; $display("FAIL loss_nwords: got %0d want 36", wq.size()); end
        for (int i = 0; i < wq.size(); i++) if (wq[i] !== exp_word(i % 12)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL loss_words: wrong=%0d want 0", errs); end
        total++; if (frame_count !== 16'd3) begin bad++; $display("FAIL loss_count: got %0d want 3", frame_count); end
        total++; if (lock_err !== 1'b1) begin bad++; $display("FAIL loss_sticky: got %b want 1", lock_err); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_relock: got %b want 1", locked); end
    endtask

    task automatic test_overflow();
        int n = 0;
        int errs = 0;
        clear_q();
        pulse_trigger();
        while (wq.size() < 4 && n < 200) begin @(posedge clk); #1; n++; end
        total++; if (n >= 200) begin bad++; $display("FAIL ovf_wait: words=%0d want 4", wq.size()); end
        // Raise fifo_full only around the 5th word-completion edge.
        repeat (4) @(negedge clk);
        fifo_full = 1'b1;
        @(negedge clk);
        fifo_full = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin @(posedge clk); #1; n++; end
        total++; if (n >= 400) begin bad++; $display("FAIL ovf_timeout: busy=%b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        total++; if (wq.size() != 16) begin bad++; $display("FAIL ovf_nwords: got %0d want 16", wq.size()); end
        for (int i = 0; i < wq.size(); i++) if (wq[i] !== exp_word(i < 4 ? i : i - 4)) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL ovf_words: wrong=%0d want 0", errs); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL ovf_count: got %0d want 1", frame_count); end
        total++; if (lock_err !== 1'b0) begin bad++; $display("FAIL ovf_lock_err: got %b want 0", lock_err); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_q();
        pulse_trigger();
        while (wq.size() < 3 && n < 200) begin @(posedge clk); #1; n++; end
        total++; if (n >= 200) begin bad++; $display("FAIL rmid_wait: words=%0d want 3", wq.size()); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL rmid_wr_en: got %b want 0", fifo_wr_en); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL rmid_data: got %h want 0", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rmid_locked: got %b want 0", locked); end
        total++; if (frame_count !== 16'h0) begin bad++; $display("FAIL rmid_count: got %0d want 0", frame_count); end
        repeat (3) @(posedge clk);
        release_reset();
        clear_q();
        repeat (150) @(posedge clk);
        #1;
        total++; if (wq.size() != 0) begin bad++; $display("FAIL rmid_nowrite: got %0d words want 0", wq.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle: busy=%b want 0", busy); end
        pulse_trigger();
        n = 0;
        while (busy !== 1'b0 && n < 400) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        total++; if (wq.size() != 12) begin bad++; $display("FAIL rmid_retrig: got %0d words want 12", wq.size()); end
    endtask

    task automatic test_zero_frames();
        int seen_busy = 0;
        clear_q();
        pulse_start(10'd0);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0) seen_busy++;
        end
        total++; if (seen_busy != 0) begin bad++; $display("FAIL zero_busy: busy cycles=%0d want 0", seen_busy); end
        total++; if (wq.size() != 0) begin bad++; $display("FAIL zero_writes: got %0d want 0", wq.size()); end
        total++; if (frame_count !== 16'h0) begin bad++; $display("FAIL zero_count: got %0d want 0", frame_count); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_auto();
        test_lock_loss();
        test_overflow();
        test_reset_mid();
        test_zero_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
